sonar_scheduler: RTL and testbench

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_pkg.sv | 22 ++
 rtl/sonar_us_tick.sv | 26 ++
 rtl/sonar_scheduler.sv | 176 +++++++++++++++++
 tb/tb_sonar_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// sonar_pkg: shared FSM state, distance constants and sizing helper
// for the round-robin ultrasonic ranging scheduler.
package sonar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  localparam int US_PER_CM = 58;
  localparam logic [8:0] CM_MAX = 9'd511;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sonar_us_tick.sv
// sonar_us_tick: microsecond strobe divider; clr restarts the count
// so a new state always sees a full first microsecond.
module sonar_us_tick #(
  parameter int CLK_PER_US = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(CLK_PER_US - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler: time-shares one ranging engine across N_SENS sensors.
// Define SONAR_SYNC_EN to pass echo through a two-flop synchronizer.
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int N_SENS = 3,
  parameter int CLK_PER_US = 100,
  parameter int TRIG_US = 10,
  parameter int ECHO_TO_US = 30000,
  parameter int GAP_US = 60000,
  localparam int IW = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_SENS-1:0] echo,
  output logic [N_SENS-1:0] trig,
  output logic              dist_valid,
  output logic [IW-1:0]     dist_id,
  output logic [8:0]        dist_cm,
  output logic              dist_timeout
);

  localparam int MAX_US = max3(TRIG_US, ECHO_TO_US, GAP_US);
  localparam int UW = $clog2(MAX_US + 1);

  state_t              state;
  logic [IW-1:0]       sel;
  logic [IW-1:0]       sel_nxt;
  logic [UW-1:0]       us_cnt;
  logic [5:0]          sub_cnt;
  logic [8:0]          cm_cnt;
  logic [8:0]          cm_inc;
  logic                sub_wrap;
  logic                tick;
  logic                leave;
  logic                echo_sel;
  logic [N_SENS-1:0]   echo_s;

`ifdef SONAR_SYNC_EN
  logic [N_SENS-1:0] echo_q1;
  logic [N_SENS-1:0] echo_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      echo_q1 <= '0;
      echo_q2 <= '0;
    end else begin
      echo_q1 <= echo;
      echo_q2 <= echo_q1;
    end
  end

  assign echo_s = echo_q2;
`else
  assign echo_s = echo;
`endif

  assign echo_sel = echo_s[sel];
  assign sel_nxt = (sel == IW'(N_SENS - 1)) ? '0 : sel + IW'(1);

  sonar_us_tick #(
    .CLK_PER_US(CLK_PER_US)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (leave),
    .tick(tick)
  );

  always_comb begin
    sub_wrap = tick && (sub_cnt == 6'(US_PER_CM - 1));
    cm_inc = cm_cnt;
    if (sub_wrap && (cm_cnt != CM_MAX)) begin
      cm_inc = cm_cnt + 9'd1;
    end
  end

  // Every state exit also restarts the divider and us counter.
  always_comb begin
    leave = 1'b0;
    unique case (state)
      S_IDLE:      leave = enable;
      S_TRIG:      leave = tick && (us_cnt == UW'(TRIG_US - 1));
      S_WAIT_RISE: leave = echo_sel ||
                           (tick && (us_cnt == UW'(ECHO_TO_US - 1)));
      S_MEASURE:   leave = !echo_sel ||
                           (tick && (us_cnt == UW'(ECHO_TO_US - 1)));
      S_GAP:       leave = tick && (us_cnt == UW'(GAP_US - 1));
      default:     leave = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sel          <= '0;
      trig         <= '0;
      us_cnt       <= '0;
      sub_cnt      <= '0;
      cm_cnt       <= '0;
      dist_valid   <= 1'b0;
      dist_id      <= '0;
      dist_cm      <= '0;
      dist_timeout <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      if (leave) begin
        us_cnt <= '0;
      end else if (tick) begin
        us_cnt <= us_cnt + UW'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_TRIG;
            trig  <= N_SENS'(1) << sel;
          end
        end
        S_TRIG: begin
          if (leave) begin
            state <= S_WAIT_RISE;
            trig  <= '0;
          end
        end
        S_WAIT_RISE: begin
          if (echo_sel) begin
            state   <= S_MEASURE;
            cm_cnt  <= '0;
            sub_cnt <= '0;
          end else if (leave) begin
            state        <= S_GAP;
            dist_valid   <= 1'b1;
            dist_id      <= sel;
            dist_cm      <= '0;
            dist_timeout <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (!echo_sel) begin
            state        <= S_GAP;
            dist_valid   <= 1'b1;
            dist_id      <= sel;
            dist_cm      <= cm_cnt;
            dist_timeout <= 1'b0;
          end else if (leave) begin
            state        <= S_GAP;
            dist_valid   <= 1'b1;
            dist_id      <= sel;
            dist_cm      <= cm_inc;
            dist_timeout <= 1'b1;
          end else if (tick) begin
            cm_cnt  <= cm_inc;
            sub_cnt <= sub_wrap ? 6'd0 : sub_cnt + 6'd1;
          end
        end
        S_GAP: begin
          if (leave) begin
            sel <= sel_nxt;
            if (enable) begin
              state <= S_TRIG;
              trig  <= N_SENS'(1) << sel_nxt;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          trig  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed checks of round-robin ranging,
// timeouts, wrap, late enable drop and reset during trigger.
module tb_sonar_scheduler;

  localparam int N_SENS = 3;
  localparam int CPU = 4;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [N_SENS-1:0] echo;
  logic [N_SENS-1:0] trig;
  logic              dist_valid;
  logic [1:0]        dist_id;
  logic [8:0]        dist_cm;
  logic              dist_timeout;

  int tests;
  int fails;

  sonar_scheduler #(
    .N_SENS(N_SENS),
    .CLK_PER_US(CPU),
    .TRIG_US(10),
    .ECHO_TO_US(3000),
    .GAP_US(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .echo(echo),
    .trig(trig),
    .dist_valid(dist_valid),
    .dist_id(dist_id),
    .dist_cm(dist_cm),
    .dist_timeout(dist_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trig != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_trig_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trig == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dist_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit ok;
  int width;
  int other_hi;
  int busy;
  int strobes;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    enable = 1'b0;
    echo = '0;
    repeat (3) @(negedge clk);

    check("rst_trig", 32'(trig), 0);
    check("rst_valid", 32'(dist_valid), 0);
    check("rst_id", 32'(dist_id), 0);
    check("rst_cm", 32'(dist_cm), 0);
    check("rst_to", 32'(dist_timeout), 0);

    rst = 1'b0;
    @(negedge clk);
    check("idle_trig", 32'(trig), 0);

    // ping 0: trigger width, then a 580 us echo
    enable = 1'b1;
    wait_trig(10, ok);
    check("trig0_seen", 32'(ok), 1);
    check("trig0_sel", 32'(trig), 1);
    width = 1;
    other_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((trig & 3'b110) != 0) other_hi++;
      if (trig[0]) width++;
      else break;
    end
    check("trig0_width", 32'(width), 40);
    check("trig0_others", 32'(other_hi), 0);
    check("trig0_low", 32'(trig), 0);

    echo = 3'b011;
    repeat (580 * CPU + 2) @(negedge clk);
    echo = 3'b000;
    wait_valid(10, ok);
    check("p0_valid", 32'(ok), 1);
    check("p0_id", 32'(dist_id), 0);
    check("p0_cm", 32'(dist_cm), 10);
    check("p0_to", 32'(dist_timeout), 0);
    @(negedge clk);
    check("p0_strobe1", 32'(dist_valid), 0);
    check("p0_hold", 32'(dist_cm), 10);

    // ping 1: silent sensor
    wait_trig(500, ok);
    check("trig1_seen", 32'(ok), 1);
    check("trig1_sel", 32'(trig), 2);
    wait_valid(40 + 3000 * CPU + 100, ok);
    check("p1_valid", 32'(ok), 1);
    check("p1_id", 32'(dist_id), 1);
    check("p1_to", 32'(dist_timeout), 1);
    check("p1_cm", 32'(dist_cm), 0);

    // ping 2: echo stuck high from the trigger on
    wait_trig(500, ok);
    check("trig2_seen", 32'(ok), 1);
    check("trig2_sel", 32'(trig), 4);
    echo = 3'b100;
    wait_valid(40 + 3000 * CPU + 100, ok);
    check("p2_valid", 32'(ok), 1);
    check("p2_id", 32'(dist_id), 2);
    check("p2_cm", 32'(dist_cm), 51);
    check("p2_to", 32'(dist_timeout), 1);
    echo = 3'b000;

    // wrap back to sensor 0; drop enable mid-measure
    wait_trig(500, ok);
    check("wrap_seen", 32'(ok), 1);
    check("wrap_sel", 32'(trig), 1);
    wait_trig_low(60, ok);
    check("p3_trig_end", 32'(ok), 1);
    echo = 3'b001;
    repeat (200) @(negedge clk);
    enable = 1'b0;
    repeat (100) @(negedge clk);
    echo = 3'b000;
    wait_valid(10, ok);
    check("p3_valid", 32'(ok), 1);
    check("p3_id", 32'(dist_id), 0);
    check("p3_cm", 32'(dist_cm), 1);
    check("p3_to", 32'(dist_timeout), 0);
    busy = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (trig != '0) busy++;
    end
    check("p3_idle", 32'(busy), 0);
    enable = 1'b1;
    wait_trig(5, ok);
    check("resume_seen", 32'(ok), 1);
    check("resume_sel", 32'(trig), 2);

    // reset in the middle of the trigger pulse
    repeat (10) @(negedge clk);
    check("pre_rst_trig", 32'(trig), 2);
    rst = 1'b1;
    strobes = 0;
    @(negedge clk);
    check("rst_mid_trig", 32'(trig), 0);
    if (dist_valid) strobes++;
    @(negedge clk);
    if (dist_valid) strobes++;
    rst = 1'b0;
    wait_trig(5, ok);
    if (dist_valid) strobes++;
    check("rst_no_report", 32'(strobes), 0);
    check("rst_next_seen", 32'(ok), 1);
    check("rst_next_sel", 32'(trig), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
